button_debounce_multi: RTL and testbench

- N-channel push-button conditioner: synchronises raw button inputs, debounces them, and emits per-channel debounced level plus single-cycle press, release, long-press and auto-repeat pulses.
- Replaces the fixed 4 Hz slow-clock two-flop edge detector with a clock-enable tick, so the whole block runs on the single system clock.
- Feeds clock-setting logic (set/increment buttons with hold-to-repeat).

---
 rtl/button_pkg.sv | 22 ++
 rtl/button_channel.sv | 137 +++++++++++++
 rtl/button_debounce_multi.sv | 76 +++++++
 tb/tb_button_debounce_multi.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner.
//   hold_state_t : per-channel hold FSM encoding (IDLE / HELD / LONG)
//   clog2_w      : counter width helper, never returns less than 1 bit
package button_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_t;

  // Bits needed to hold values 0..value-1 (minimum 1 bit).
  function automatic int clog2_w(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: two-flop synchroniser, tick-sampled debounce counter,
// hold FSM and registered single-cycle event pulses.
// Ports:
//   i_clk, i_rst      system clock, asynchronous active-high reset
//   i_tick            shared sample enable (one cycle wide)
//   i_pb              raw asynchronous button input, 1 = pressed
//   o_level           debounced button level
//   o_press/o_release one-cycle pulses on debounced rise/fall
//   o_long_press      one-cycle pulse after LONG_TICKS ticks of hold
//   o_repeat_pulse    one-cycle pulse every REPEAT_TICKS ticks after long press
//   o_state           current hold FSM state (debug)
module button_channel
  import button_pkg::*;
#(
  parameter int DEB_SAMPLES  = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 250
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tick,
  input  logic        i_pb,
  output logic        o_level,
  output logic        o_press,
  output logic        o_release,
  output logic        o_long_press,
  output logic        o_repeat_pulse,
  output hold_state_t o_state
);

  localparam int DEB_W    = clog2_w(DEB_SAMPLES + 1);
  localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HOLD_W   = clog2_w(HOLD_MAX + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_SAMPLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

  logic              r_sync1;
  logic              r_s;
  logic              r_level;
  logic              r_press;
  logic              r_release;
  logic              r_long;
  logic              r_repeat;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  hold_state_t       r_state;
  logic              w_accept;

  // The sample that completes the run of differing ticks flips the level.
  assign w_accept = i_tick && (r_s != r_level) && (r_deb_cnt == DEB_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_s        <= 1'b0;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
      r_deb_cnt  <= '0;
      r_hold_cnt <= '0;
      r_state    <= IDLE;
    end else begin
      r_sync1   <= i_pb;
      r_s       <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;

      if (i_tick) begin
        // Debounce counter
        if (r_s == r_level) begin
          r_deb_cnt <= '0;
        end else if (w_accept) begin
          r_deb_cnt <= '0;
          r_level   <= ~r_level;
        end else begin
          r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end

        // Hold FSM; a fall outranks any long/repeat due on this tick.
        if (w_accept && r_level) begin
          r_release  <= 1'b1;
          r_state    <= IDLE;
          r_hold_cnt <= '0;
        end else begin
          case (r_state)
            IDLE: begin
              if (w_accept) begin
                r_press    <= 1'b1;
                r_state    <= HELD;
                r_hold_cnt <= '0;
              end
            end
            HELD: begin
              if (r_hold_cnt == LONG_LAST) begin
                r_long     <= 1'b1;
                r_hold_cnt <= '0;
                r_state    <= LONG;
              end else begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
              end
            end
            LONG: begin
              if (REPEAT_TICKS == 0) begin
                // No repeat: count up to all-ones and stay there.
                if (r_hold_cnt != HOLD_SAT) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
              end else if (r_hold_cnt == REP_LAST) begin
                r_repeat   <= 1'b1;
                r_hold_cnt <= '0;
              end else begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
              end
            end
            default: begin
              r_state    <= IDLE;
              r_hold_cnt <= '0;
            end
          endcase
        end
      end
    end
  end

  assign o_level        = r_level;
  assign o_press        = r_press;
  assign o_release      = r_release;
  assign o_long_press   = r_long;
  assign o_repeat_pulse = r_repeat;
  assign o_state        = r_state;

endmodule

// File: rtl/button_debounce_multi.sv
// N-channel push-button conditioner on a single system clock.
// A shared divider produces a one-cycle sample tick every TICK_DIV cycles;
// each channel debounces on that tick and reports level and event pulses.
// Ports:
//   i_clk_in        system clock
//   i_rst           asynchronous active-high reset
//   i_pb            raw button inputs, 1 = pressed
//   o_level         debounced levels
//   o_press         one-cycle pulse on debounced 0->1
//   o_release       one-cycle pulse on debounced 1->0
//   o_long_press    one-cycle pulse after LONG_TICKS ticks held
//   o_repeat_pulse  one-cycle pulse every REPEAT_TICKS ticks after long press
//   o_dbg_state     hold FSM state, 2 bits per channel (channel g at [2g+1:2g])
module button_debounce_multi
  import button_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 100000,
  parameter int DEB_SAMPLES  = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 250
) (
  input  logic               i_clk_in,
  input  logic               i_rst,
  input  logic [N_BTN-1:0]   i_pb,
  output logic [N_BTN-1:0]   o_level,
  output logic [N_BTN-1:0]   o_press,
  output logic [N_BTN-1:0]   o_release,
  output logic [N_BTN-1:0]   o_long_press,
  output logic [N_BTN-1:0]   o_repeat_pulse,
  output logic [2*N_BTN-1:0] o_dbg_state
);

  localparam int                TICK_W    = clog2_w(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  // With TICK_DIV = 1 the counter sits at 0 == TICK_LAST, so tick is always 1.
  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    hold_state_t w_state;

    button_channel #(
      .DEB_SAMPLES (DEB_SAMPLES),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_channel (
      .i_clk         (i_clk_in),
      .i_rst         (i_rst),
      .i_tick        (w_tick),
      .i_pb          (i_pb[g]),
      .o_level       (o_level[g]),
      .o_press       (o_press[g]),
      .o_release     (o_release[g]),
      .o_long_press  (o_long_press[g]),
      .o_repeat_pulse(o_repeat_pulse[g]),
      .o_state       (w_state)
    );

    assign o_dbg_state[2*g +: 2] = w_state;
  end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Bench for button_debounce_multi: two instances (repeat every 4 ticks and
// repeat disabled) share one stimulus. A tick-level model derives the expected
// outputs for every cycle; literal checks pin latencies and pulse counts.
module tb_button_debounce_multi;

  localparam int N    = 2;
  localparam int TD   = 4;
  localparam int DEB  = 3;
  localparam int LONG = 10;
  localparam int REP  = 4;
  localparam int VW   = 5 * N;

  // ---------------- clock / reset ----------------
  logic         clk_in = 1'b0;
  logic         rst    = 1'b1;
  logic [N-1:0] pb     = '0;

  always #5 clk_in = ~clk_in;

  logic [N-1:0]   lvl_a, prs_a, rel_a, lng_a, rep_a;
  logic [N-1:0]   lvl_b, prs_b, rel_b, lng_b, rep_b;
  logic [2*N-1:0] dbg_a, dbg_b;

  button_debounce_multi #(
    .N_BTN(N), .TICK_DIV(TD), .DEB_SAMPLES(DEB), .LONG_TICKS(LONG), .REPEAT_TICKS(REP)
  ) dut_a (
    .i_clk_in(clk_in), .i_rst(rst), .i_pb(pb),
    .o_level(lvl_a), .o_press(prs_a), .o_release(rel_a),
    .o_long_press(lng_a), .o_repeat_pulse(rep_a), .o_dbg_state(dbg_a)
  );

  button_debounce_multi #(
    .N_BTN(N), .TICK_DIV(TD), .DEB_SAMPLES(DEB), .LONG_TICKS(LONG), .REPEAT_TICKS(0)
  ) dut_b (
    .i_clk_in(clk_in), .i_rst(rst), .i_pb(pb),
    .o_level(lvl_b), .o_press(prs_b), .o_release(rel_b),
    .o_long_press(lng_b), .o_repeat_pulse(rep_b), .o_dbg_state(dbg_b)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [2*VW-1:0] exp_q[$];

  int cnt_prs[N], cnt_rel[N], cnt_lng[N], cnt_rep[N];
  int cnt_lng_b[N], cnt_rep_b[N];

  // ---------------- behavioural model ----------------
  // Works in terms of "tick samples seen since the last accepted change" and
  // "ticks held since the press"; long press at LONG ticks held, repeats at
  // LONG + k*REP ticks held.
  int           n_cyc;
  logic [N-1:0] m_q0, m_q1, m_lvl;
  logic [15:0]  m_win[N];
  int           m_since[N];
  int           m_held[N];

  always @(posedge clk_in or posedge rst) begin
    logic [N-1:0] s, e_prs, e_rel, e_lng, e_rep;
    logic         tick;
    logic         acc;
    e_prs = '0; e_rel = '0; e_lng = '0; e_rep = '0;
    if (rst) begin
      n_cyc = 0;
      m_q0  = '0;
      m_q1  = '0;
      m_lvl = '0;
      for (int c = 0; c < N; c++) begin
        m_win[c] = '0; m_since[c] = 0; m_held[c] = 0;
      end
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      n_cyc++;
      s    = m_q1;
      m_q1 = m_q0;
      m_q0 = pb;
      tick = ((n_cyc % TD) == 0);
      if (tick) begin
        for (int c = 0; c < N; c++) begin
          m_win[c] = {m_win[c][14:0], s[c]};
          m_since[c]++;
          acc = (m_since[c] >= DEB);
          for (int k = 0; k < DEB; k++) if (m_win[c][k] == m_lvl[c]) acc = 1'b0;
          if (acc) begin
            m_since[c] = 0;
            if (m_lvl[c]) e_rel[c] = 1'b1;
            else begin e_prs[c] = 1'b1; m_held[c] = 0; end
            m_lvl[c] = ~m_lvl[c];
          end else if (m_lvl[c]) begin
            m_held[c]++;
            if (m_held[c] == LONG) e_lng[c] = 1'b1;
            if (m_held[c] > LONG && ((m_held[c] - LONG) % REP) == 0) e_rep[c] = 1'b1;
          end
        end
      end
      exp_q.push_back({e_rep, e_lng, e_rel, e_prs, m_lvl,
                       {N{1'b0}}, e_lng, e_rel, e_prs, m_lvl});
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [2*VW-1:0] act, exp;
    forever begin
      @(negedge clk_in);
      act = {rep_a, lng_a, rel_a, prs_a, lvl_a, rep_b, lng_b, rel_b, prs_b, lvl_b};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL cycle_compare t=%0t: got %h, required value missing", $time, act);
      end else begin
        while (exp_q.size() > 1) void'(exp_q.pop_front());
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_err++;
          $display("FAIL cycle_compare t=%0t: got %h, required %h", $time, act, exp);
        end
      end
      for (int c = 0; c < N; c++) begin
        cnt_prs[c]   += int'(prs_a[c]);
        cnt_rel[c]   += int'(rel_a[c]);
        cnt_lng[c]   += int'(lng_a[c]);
        cnt_rep[c]   += int'(rep_a[c]);
        cnt_lng_b[c] += int'(lng_b[c]);
        cnt_rep_b[c] += int'(rep_b[c]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Cycles until lvl_a[ch] equals val; budget+1 if it never does.
  task automatic wait_level(input int ch, input logic val, input int budget, output int lat);
    lat = budget + 1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk_in);
      if (lvl_a[ch] === val) begin
        lat = k;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int p0, r0, l0, q0, p1, r1, l1, lb0, qb0;

    wait_cycles(3);
    check_eq("reset_outputs", int'({lvl_a, prs_a, rel_a, lng_a, rep_a, lvl_b, prs_b, rel_b, lng_b, rep_b}), 0);
    rst = 1'b0;
    wait_cycles(10);

    // Clean press held 20 cycles on ch0
    p0 = cnt_prs[0]; r0 = cnt_rel[0]; l0 = cnt_lng[0];
    pb[0] = 1'b1;
    wait_level(0, 1'b1, 20, lat);
    check_range("s1_rise_latency", lat, 11, 15);
    wait_cycles((lat < 20) ? 20 - lat : 0);
    pb[0] = 1'b0;
    wait_level(0, 1'b0, 20, lat);
    check_range("s1_fall_latency", lat, 11, 15);
    wait_cycles(20);
    check_eq("s1_press_count", cnt_prs[0] - p0, 1);
    check_eq("s1_release_count", cnt_rel[0] - r0, 1);
    check_eq("s1_long_count", cnt_lng[0] - l0, 0);

    // Bounce on ch1 (toggle every 3 cycles), then steady high
    p1 = cnt_prs[1]; r1 = cnt_rel[1];
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) pb[1] = ~pb[1];
      wait_cycles(1);
    end
    check_eq("s2_bounce_press", cnt_prs[1] - p1, 0);
    check_eq("s2_bounce_release", cnt_rel[1] - r1, 0);
    pb[1] = 1'b1;
    wait_cycles(20);
    check_eq("s2_steady_press", cnt_prs[1] - p1, 1);
    pb[1] = 1'b0;
    wait_cycles(20);

    // Long hold on ch0 for 80 ticks
    p0 = cnt_prs[0]; r0 = cnt_rel[0]; l0 = cnt_lng[0]; q0 = cnt_rep[0];
    lb0 = cnt_lng_b[0]; qb0 = cnt_rep_b[0];
    pb[0] = 1'b1;
    wait_cycles(318);
    check_eq("s3_state_long_a", int'(dbg_a[1:0]), 2);
    check_eq("s3_state_long_b", int'(dbg_b[1:0]), 2);
    wait_cycles(2);
    pb[0] = 1'b0;
    wait_cycles(20);
    check_eq("s3_press_count", cnt_prs[0] - p0, 1);
    check_eq("s3_long_count", cnt_lng[0] - l0, 1);
    check_eq("s3_repeat_count", cnt_rep[0] - q0, 17);
    check_eq("s3_release_count", cnt_rel[0] - r0, 1);
    check_eq("s3_norep_long_count", cnt_lng_b[0] - lb0, 1);
    check_eq("s3_norep_repeat_count", cnt_rep_b[0] - qb0, 0);

    // Both channels pressed together, ch1 released early
    l0 = cnt_lng[0]; l1 = cnt_lng[1]; r1 = cnt_rel[1];
    pb = 2'b11;
    wait_level(0, 1'b1, 20, lat);
    check_range("s4_rise_latency", lat, 11, 15);
    wait_cycles(20);
    pb[1] = 1'b0;
    wait_cycles(40);
    check_eq("s4_ch0_long", cnt_lng[0] - l0, 1);
    check_eq("s4_ch1_long", cnt_lng[1] - l1, 0);
    check_eq("s4_ch1_release", cnt_rel[1] - r1, 1);
    pb[0] = 1'b0;
    wait_cycles(20);

    // Reset while ch0 is in LONG with the button still held
    pb[0] = 1'b1;
    wait_cycles(60);
    check_eq("s5_state_long", int'(dbg_a[1:0]), 2);
    p0 = cnt_prs[0]; r0 = cnt_rel[0];
    #2 rst = 1'b1;
    #1 check_eq("s5_reset_outputs", int'({lvl_a, prs_a, rel_a, lng_a, rep_a, lvl_b, prs_b, rel_b, lng_b, rep_b}), 0);
    wait_cycles(3);
    rst = 1'b0;
    wait_level(0, 1'b1, 20, lat);
    check_range("s5_repress_latency", lat, 11, 15);
    wait_cycles(2);
    check_eq("s5_no_release", cnt_rel[0] - r0, 0);
    check_eq("s5_press_count", cnt_prs[0] - p0, 1);
    pb[0] = 1'b0;
    wait_cycles(20);

    // Randomised patterns: short glitches and long holds on both channels
    for (int it = 0; it < 40; it++) begin
      pb = 2'($urandom_range(0, 3));
      wait_cycles($urandom_range(1, 60));
    end
    pb = '0;
    wait_cycles(30);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
